// File: rtl/rv_pkg.sv
// Shared core constants and types: default datapath width, register count and register address type.
package rv_pkg;

    localparam int unsigned RV_XLEN  = 32;
    localparam int unsigned RV_NREGS = 32;
    localparam int unsigned RV_AW    = $clog2(RV_NREGS);

    typedef logic [RV_AW-1:0] reg_addr_t;

endpackage : rv_pkg

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set by a reservation at issue, cleared by writeback; r0 is never busy.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter  int unsigned NREGS = RV_NREGS,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_num,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_num,
    input  logic [AW-1:0] q_num_1,
    input  logic [AW-1:0] q_num_2,
    output logic          busy_1_c,
    output logic          busy_2_c,
    output logic          hazard_c
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Reservation is applied after the clear so a new producer wins a same-edge collision.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_num] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_num] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Queries see the post-update state; hazard looks at the state before this edge.
    assign busy_1_c = busy_d[q_num_1];
    assign busy_2_c = busy_d[q_num_2];
    assign hazard_c = rsv_en && busy_q[rsv_num];

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with registered read ports, optional write bypass and a busy scoreboard.
module reg_file_sb
    import rv_pkg::*;
#(
    parameter  int unsigned XLEN   = RV_XLEN,
    parameter  int unsigned NREGS  = RV_NREGS,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [AW-1:0]   reg_num_1,
    input  logic [AW-1:0]   reg_num_2,
    output logic [XLEN-1:0] rs_1,
    output logic [XLEN-1:0] rs_2,
    output logic            busy_1,
    output logic            busy_2,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_num,
    input  logic [XLEN-1:0] wr_val,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_num,
    output logic            hazard
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rd_val_1_c;
    logic [XLEN-1:0] rd_val_2_c;
    logic            sb_busy_1_c;
    logic            sb_busy_2_c;
    logic            wr_hit_c;

    assign wr_hit_c = wr_en && (wr_num != '0);

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (rsv_en),
        .rsv_num  (rsv_num),
        .clr_en   (wr_en),
        .clr_num  (wr_num),
        .q_num_1  (reg_num_1),
        .q_num_2  (reg_num_2),
        .busy_1_c (sb_busy_1_c),
        .busy_2_c (sb_busy_2_c),
        .hazard_c (hazard)
    );

    // Data array; slot 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_hit_c) begin
            regs_q[wr_num] <= wr_val;
        end
    end

    // Read muxes with optional same-edge forwarding of the writeback value.
    always_comb begin
        rd_val_1_c = regs_q[reg_num_1];
        rd_val_2_c = regs_q[reg_num_2];
        if ((BYPASS != 0) && wr_hit_c && (wr_num == reg_num_1)) begin
            rd_val_1_c = wr_val;
        end
        if ((BYPASS != 0) && wr_hit_c && (wr_num == reg_num_2)) begin
            rd_val_2_c = wr_val;
        end
        if (reg_num_1 == '0) begin
            rd_val_1_c = '0;
        end
        if (reg_num_2 == '0) begin
            rd_val_2_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_1   <= '0;
            rs_2   <= '0;
            busy_1 <= 1'b0;
            busy_2 <= 1'b0;
        end else if (rd_en) begin
            rs_1   <= rd_val_1_c;
            rs_2   <= rd_val_2_c;
            busy_1 <= sb_busy_1_c;
            busy_2 <= sb_busy_2_c;
        end
    end

endmodule : reg_file_sb
